// File: rtl/frame_compare_buffer_if.sv
// Stream and result bundle for frame_compare_buffer: reference/compare word streams in, per-frame verdict out.
// Both streams are strobe-only (valid with no ready): a word is taken in every cycle its valid is high.
interface frame_compare_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1536
);
    localparam int AW = $clog2(DEPTH) + 1;

    logic              ref_valid;
    logic [DATA_W-1:0] ref_data;
    logic              ref_last;
    logic              ref_clear;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_data;
    logic              cmp_last;

    logic              ref_loaded;
    logic [AW-1:0]     ref_len;
    logic              ref_ovf;
    logic              done;
    logic              match;
    logic [AW-1:0]     mismatch_cnt;
    logic [AW-1:0]     first_mis;
    logic [1:0]        dbg_state;

    modport master (
        output ref_valid, ref_data, ref_last, ref_clear, cmp_valid, cmp_data, cmp_last,
        input  ref_loaded, ref_len, ref_ovf, done, match, mismatch_cnt, first_mis, dbg_state
    );

    modport slave (
        input  ref_valid, ref_data, ref_last, ref_clear, cmp_valid, cmp_data, cmp_last,
        output ref_loaded, ref_len, ref_ovf, done, match, mismatch_cnt, first_mis, dbg_state
    );
endinterface

// File: rtl/frame_compare_buffer.sv
// Reference frame store plus byte-wise comparator; a stored reference is checked against any number of frames.
// Pipeline: stage 0 accepts a word and reads RAM, stage 1 compares and folds the outcome into the result registers.
module frame_compare_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1536
) (
    input logic                   clk,
    input logic                   rst,
    frame_compare_buffer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH) + 1;
    localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ALL_ONES = '1;
    localparam logic [AW-1:0] DEPTH_W  = AW'(DEPTH);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [1:0] {
        S_EMPTY     = 2'd0,
        S_LOADING   = 2'd1,
        S_LOADED    = 2'd2,
        S_COMPARING = 2'd3
    } state_t;

    state_t r_state, w_next_state;

    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    logic [AW-1:0]     r_wr_idx;
    logic [AW-1:0]     r_ref_len;
    logic              r_ref_ovf;
    logic [AW-1:0]     r_cmp_idx;

    logic              r_s1_valid;
    logic              r_s1_start;
    logic              r_s1_last;
    logic              r_s1_inrange;
    logic [DATA_W-1:0] r_s1_data;
    logic [AW-1:0]     r_s1_idx;

    logic              r_done;
    logic              r_match;
    logic [AW-1:0]     r_mis_cnt;
    logic [AW-1:0]     r_first_mis;

    logic              w_clear;
    logic              w_ref_acc;
    logic              w_wr_en;
    logic              w_cmp_acc;
    logic [AW-1:0]     w_k;
    logic              w_s1_mis;
    logic [AW-1:0]     w_base_cnt;
    logic [AW-1:0]     w_base_first;
    logic [AW:0]       w_cmp_len;
    logic              w_short;
    logic [AW:0]       w_diff;
    logic [AW:0]       w_sum;
    logic [AW-1:0]     w_new_cnt;
    logic [AW-1:0]     w_new_first;

    assign w_clear   = bus.ref_clear;
    assign w_ref_acc = !w_clear && bus.ref_valid && (r_state == S_EMPTY || r_state == S_LOADING);
    // The write index is zero whenever the FSM sits in EMPTY, so one address path covers both load states.
    assign w_wr_en   = w_ref_acc && (r_wr_idx < DEPTH_W);
    assign w_cmp_acc = !w_clear && bus.cmp_valid && (r_state == S_LOADED || r_state == S_COMPARING);
    assign w_k       = (r_state == S_LOADED) ? '0 : r_cmp_idx;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY:     if (bus.ref_valid) w_next_state = bus.ref_last ? S_LOADED : S_LOADING;
            S_LOADING:   if (bus.ref_valid && bus.ref_last) w_next_state = S_LOADED;
            S_LOADED:    if (bus.cmp_valid && !bus.cmp_last) w_next_state = S_COMPARING;
            S_COMPARING: if (bus.cmp_valid && bus.cmp_last) w_next_state = S_LOADED;
            default:     w_next_state = S_EMPTY;
        endcase
        if (w_clear) w_next_state = S_EMPTY;
    end

    // Counters restart at the first word's stage-1 update, so a back-to-back frame never disturbs the
    // previous frame's result while it is being presented.
    always_comb begin
        w_s1_mis     = !r_s1_inrange || (r_rd_data != r_s1_data);
        w_base_cnt   = r_s1_start ? '0 : r_mis_cnt;
        w_base_first = r_s1_start ? ALL_ONES : r_first_mis;
        w_cmp_len    = {1'b0, r_s1_idx} + {{AW{1'b0}}, 1'b1};
        w_short      = r_s1_last && (w_cmp_len < {1'b0, r_ref_len});
        w_diff       = w_short ? ({1'b0, r_ref_len} - w_cmp_len) : '0;
        w_sum        = {1'b0, w_base_cnt} + {{AW{1'b0}}, w_s1_mis} + w_diff;
        w_new_cnt    = (w_sum > {1'b0, ALL_ONES}) ? ALL_ONES : w_sum[AW-1:0];
        w_new_first  = w_base_first;
        if (w_s1_mis && w_new_first == ALL_ONES) w_new_first = r_s1_idx;
        if (w_short && w_new_first == ALL_ONES) w_new_first = w_cmp_len[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_ram[r_wr_idx[RAW-1:0]] <= bus.ref_data;
        r_rd_data <= r_ram[w_k[RAW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_wr_idx     <= '0;
            r_ref_len    <= '0;
            r_ref_ovf    <= 1'b0;
            r_cmp_idx    <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_start   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_inrange <= 1'b0;
            r_s1_data    <= '0;
            r_s1_idx     <= '0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
            r_mis_cnt    <= '0;
            r_first_mis  <= ALL_ONES;
        end else begin
            r_state <= w_next_state;
            if (w_clear) begin
                r_wr_idx   <= '0;
                r_ref_len  <= '0;
                r_ref_ovf  <= 1'b0;
                r_cmp_idx  <= '0;
                r_s1_valid <= 1'b0;
                r_s1_last  <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                if (w_wr_en) r_wr_idx <= r_wr_idx + ONE;
                if (w_ref_acc && !w_wr_en) r_ref_ovf <= 1'b1;
                if (w_ref_acc && bus.ref_last) r_ref_len <= w_wr_en ? (r_wr_idx + ONE) : DEPTH_W;
                if (w_cmp_acc) r_cmp_idx <= (w_k == ALL_ONES) ? ALL_ONES : (w_k + ONE);

                r_s1_valid   <= w_cmp_acc;
                r_s1_start   <= (r_state == S_LOADED);
                r_s1_last    <= bus.cmp_last;
                r_s1_inrange <= (w_k < r_ref_len);
                r_s1_data    <= bus.cmp_data;
                r_s1_idx     <= w_k;

                r_done <= r_s1_valid && r_s1_last;
                if (r_s1_valid) begin
                    r_mis_cnt   <= w_new_cnt;
                    r_first_mis <= w_new_first;
                    if (r_s1_last)       r_match <= (w_new_cnt == '0);
                    else if (r_s1_start) r_match <= 1'b0;
                end
            end
        end
    end

    assign bus.ref_loaded   = (r_state == S_LOADED) || (r_state == S_COMPARING);
    assign bus.ref_len      = r_ref_len;
    assign bus.ref_ovf      = r_ref_ovf;
    assign bus.done         = r_done;
    assign bus.match        = r_match;
    assign bus.mismatch_cnt = r_mis_cnt;
    assign bus.first_mis    = r_first_mis;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_frame_compare_buffer.sv
// Directed bench for frame_compare_buffer: reference loads, compare frames, back-to-back, clear, overflow, reset.
module tb_frame_compare_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1536;
    localparam int AW     = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] ALL = '1;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    frame_compare_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    frame_compare_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ref_valid = 1'b0;
        bus.ref_data  = '0;
        bus.ref_last  = 1'b0;
        bus.ref_clear = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.cmp_data  = '0;
        bus.cmp_last  = 1'b0;
    endtask

    task automatic load_ref(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ref_valid = 1'b1;
            bus.ref_data  = i[7:0];
            bus.ref_last  = (i == n - 1);
            step();
        end
        idle();
    endtask

    task automatic clear_ref();
        bus.ref_clear = 1'b1;
        step();
        idle();
    endtask

    // Streams words i[7:0] (inverted at inv_a/inv_b) and samples done at T+1..T+3, results at T+2.
    task automatic run_frame(input int n, input int inv_a, input int inv_b,
                             output logic d1, output logic d2, output logic d3, output logic m,
                             output logic [AW-1:0] cnt, output logic [AW-1:0] first);
        for (int i = 0; i < n; i++) begin
            bus.cmp_valid = 1'b1;
            bus.cmp_data  = i[7:0] ^ ((i == inv_a || i == inv_b) ? 8'hFF : 8'h00);
            bus.cmp_last  = (i == n - 1);
            step();
        end
        idle();
        d1 = bus.done;
        step();
        d2    = bus.done;
        m     = bus.match;
        cnt   = bus.mismatch_cnt;
        first = bus.first_mis;
        step();
        d3 = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) step();
        rst = 1'b0;
        tests_run++;
        if (bus.dbg_state !== 2'd0 || bus.ref_loaded !== 1'b0 || bus.ref_len !== '0 || bus.ref_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ref: state=%0d loaded=%0b len=%0d ovf=%0b, expected 0 0 0 0",
                     bus.dbg_state, bus.ref_loaded, bus.ref_len, bus.ref_ovf);
        end
        tests_run++;
        if (bus.done !== 1'b0 || bus.match !== 1'b0 || bus.mismatch_cnt !== '0 || bus.first_mis !== ALL) begin
            tests_failed++;
            $display("FAIL reset_result: done=%0b match=%0b cnt=%0d first=%0d, expected 0 0 0 %0d",
                     bus.done, bus.match, bus.mismatch_cnt, bus.first_mis, ALL);
        end
        // compare words while EMPTY must leave no trace
        bus.cmp_valid = 1'b1;
        bus.cmp_last  = 1'b1;
        repeat (3) step();
        idle();
        step();
        step();
        tests_run++;
        if (bus.dbg_state !== 2'd0 || bus.done !== 1'b0 || bus.first_mis !== ALL) begin
            tests_failed++;
            $display("FAIL cmp_in_empty: state=%0d done=%0b first=%0d, expected 0 0 %0d",
                     bus.dbg_state, bus.done, bus.first_mis, ALL);
        end
    endtask

    task automatic test_identical();
        logic d1, d2, d3, m;
        logic [AW-1:0] cnt, first;
        load_ref(60);
        tests_run++;
        if (bus.ref_loaded !== 1'b1 || bus.ref_len !== AW'(60)) begin
            tests_failed++;
            $display("FAIL ref_loaded_t1: loaded=%0b len=%0d, expected 1 60", bus.ref_loaded, bus.ref_len);
        end
        run_frame(60, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if ({d1, d2, d3} !== 3'b010) begin
            tests_failed++;
            $display("FAIL identical_done_timing: done T+1..T+3=%b, expected 010", {d1, d2, d3});
        end
        tests_run++;
        if (m !== 1'b1 || cnt !== '0 || first !== ALL) begin
            tests_failed++;
            $display("FAIL identical_result: match=%0b cnt=%0d first=%0d, expected 1 0 %0d", m, cnt, first, ALL);
        end
    endtask

    task automatic test_errors();
        logic d1, d2, d3, m;
        logic [AW-1:0] cnt, first;
        run_frame(60, 5, 40, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== AW'(2) || first !== AW'(5)) begin
            tests_failed++;
            $display("FAIL two_errors: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 2 5", d2, m, cnt, first);
        end
        tests_run++;
        if (bus.match !== 1'b0 || bus.mismatch_cnt !== AW'(2)) begin
            tests_failed++;
            $display("FAIL result_hold: match=%0b cnt=%0d, expected 0 2", bus.match, bus.mismatch_cnt);
        end
    endtask

    task automatic test_short_long();
        logic d1, d2, d3, m;
        logic [AW-1:0] cnt, first;
        run_frame(50, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== AW'(10) || first !== AW'(50)) begin
            tests_failed++;
            $display("FAIL short_frame: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 10 50", d2, m, cnt, first);
        end
        run_frame(64, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== AW'(4) || first !== AW'(60)) begin
            tests_failed++;
            $display("FAIL long_frame: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 4 60", d2, m, cnt, first);
        end
    endtask

    task automatic test_back_to_back();
        int cyc_q[$];
        logic match_q[$];
        logic [AW-1:0] cnt_q[$];
        int cyc;
        cyc = 0;
        for (int g = 0; g < 183; g++) begin
            if (g < 180) begin
                bus.cmp_valid = 1'b1;
                bus.cmp_data  = (g % 60) & 8'hFF;
                if (g == 67) bus.cmp_data = bus.cmp_data ^ 8'hFF;
                bus.cmp_last  = ((g % 60) == 59);
            end else begin
                idle();
            end
            step();
            cyc = g + 1;
            if (bus.done === 1'b1) begin
                cyc_q.push_back(cyc);
                match_q.push_back(bus.match);
                cnt_q.push_back(bus.mismatch_cnt);
            end
        end
        tests_run++;
        if (cyc_q.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_pulses: %0d done pulses, expected 3", cyc_q.size());
        end else begin
            tests_run++;
            if (cyc_q[0] != 61 || cyc_q[1] != 121 || cyc_q[2] != 181) begin
                tests_failed++;
                $display("FAIL b2b_timing: done at %0d %0d %0d, expected 61 121 181", cyc_q[0], cyc_q[1], cyc_q[2]);
            end
            tests_run++;
            if ({match_q[0], match_q[1], match_q[2]} !== 3'b101 || cnt_q[1] !== AW'(1)) begin
                tests_failed++;
                $display("FAIL b2b_match: match=%b cnt2=%0d, expected 101 1",
                         {match_q[0], match_q[1], match_q[2]}, cnt_q[1]);
            end
        end
    endtask

    task automatic test_clear_with_last();
        logic seen_done;
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.cmp_valid = 1'b1;
            bus.cmp_data  = i[7:0];
            bus.cmp_last  = (i == 59);
            bus.ref_clear = (i == 59);
            step();
        end
        idle();
        for (int j = 0; j < 3; j++) begin
            if (bus.done === 1'b1) seen_done = 1'b1;
            step();
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_no_done: done seen=%0b, expected 0", seen_done);
        end
        tests_run++;
        if (bus.dbg_state !== 2'd0 || bus.ref_loaded !== 1'b0 || bus.ref_len !== '0) begin
            tests_failed++;
            $display("FAIL clear_state: state=%0d loaded=%0b len=%0d, expected 0 0 0",
                     bus.dbg_state, bus.ref_loaded, bus.ref_len);
        end
    endtask

    task automatic test_overflow();
        logic d1, d2, d3, m;
        logic [AW-1:0] cnt, first;
        load_ref(DEPTH + 3);
        tests_run++;
        if (bus.ref_ovf !== 1'b1 || bus.ref_len !== AW'(DEPTH) || bus.ref_loaded !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_load: ovf=%0b len=%0d loaded=%0b, expected 1 %0d 1",
                     bus.ref_ovf, bus.ref_len, bus.ref_loaded, DEPTH);
        end
        run_frame(2000, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== AW'(464) || first !== AW'(DEPTH)) begin
            tests_failed++;
            $display("FAIL ovf_compare: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 464 %0d",
                     d2, m, cnt, first, DEPTH);
        end
        clear_ref();
        tests_run++;
        if (bus.ref_ovf !== 1'b0 || bus.ref_len !== '0 || bus.dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%0b len=%0d state=%0d, expected 0 0 0",
                     bus.ref_ovf, bus.ref_len, bus.dbg_state);
        end
    endtask

    task automatic test_saturation();
        logic d1, d2, d3, m;
        logic [AW-1:0] cnt, first;
        load_ref(1);
        tests_run++;
        if (bus.ref_loaded !== 1'b1 || bus.ref_len !== AW'(1)) begin
            tests_failed++;
            $display("FAIL single_ref: loaded=%0b len=%0d, expected 1 1", bus.ref_loaded, bus.ref_len);
        end
        run_frame(4200, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== ALL || first !== AW'(1)) begin
            tests_failed++;
            $display("FAIL saturate: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 %0d 1", d2, m, cnt, first, ALL);
        end
        run_frame(1, -1, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if ({d1, d2, d3} !== 3'b010 || m !== 1'b1 || cnt !== '0 || first !== ALL) begin
            tests_failed++;
            $display("FAIL single_word_ok: done=%b match=%0b cnt=%0d first=%0d, expected 010 1 0 %0d",
                     {d1, d2, d3}, m, cnt, first, ALL);
        end
        run_frame(1, 0, -1, d1, d2, d3, m, cnt, first);
        tests_run++;
        if (d2 !== 1'b1 || m !== 1'b0 || cnt !== AW'(1) || first !== '0) begin
            tests_failed++;
            $display("FAIL single_word_bad: done=%0b match=%0b cnt=%0d first=%0d, expected 1 0 1 0", d2, m, cnt, first);
        end
    endtask

    task automatic test_rst_mid_load();
        clear_ref();
        for (int i = 0; i < 10; i++) begin
            bus.ref_valid = 1'b1;
            bus.ref_data  = i[7:0];
            step();
        end
        tests_run++;
        if (bus.dbg_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL mid_load_state: state=%0d, expected 1", bus.dbg_state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        tests_run++;
        if (bus.dbg_state !== 2'd0 || bus.ref_loaded !== 1'b0 || bus.ref_len !== '0 || bus.ref_ovf !== 1'b0 ||
            bus.done !== 1'b0 || bus.match !== 1'b0 || bus.mismatch_cnt !== '0 || bus.first_mis !== ALL) begin
            tests_failed++;
            $display("FAIL rst_mid_load: state=%0d loaded=%0b len=%0d ovf=%0b done=%0b match=%0b cnt=%0d first=%0d, expected reset values",
                     bus.dbg_state, bus.ref_loaded, bus.ref_len, bus.ref_ovf, bus.done, bus.match,
                     bus.mismatch_cnt, bus.first_mis);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_identical();
        test_errors();
        test_short_long();
        test_back_to_back();
        test_clear_with_last();
        test_overflow();
        test_saturation();
        test_rst_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
